// File: rtl/mult_requester.sv
`default_nettype none
// =============================================================================
// Module      : mult_requester
// Description : Drives the multiplier peripheral's register protocol.
//               A, B and START writes, status polling, then the RESULT read,
//               with the outcome returned on a valid/ready stream.
// Revision    : 1.0 - initial release
// =============================================================================
module mult_requester #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_product,
   output logic        out_err,
   output logic [1:0]  sel,
   output logic        wstrb,
   output logic        rstrb,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        wbusy
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_FREE = 3'd1,
      S_WR_A      = 3'd2,
      S_WR_B      = 3'd3,
      S_WR_START  = 3'd4,
      S_POLL      = 3'd5,
      S_RD_RES    = 3'd6,
      S_OUT       = 3'd7
   } state_t;

   localparam logic [15:0] c_timeout = 16'(TIMEOUT);

   state_t      r_state;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [15:0] r_cnt;
   logic [31:0] r_prod;
   logic        r_err;
   logic        r_valid;
   logic [1:0]  r_sel;
   logic        r_wstrb;
   logic        r_rstrb;
   logic [31:0] r_wdata;
   logic [15:0] w_cnt_inc;

   // Wait counter saturates so a stuck peripheral cannot wrap it past the limit
   assign w_cnt_inc = (r_cnt == c_timeout) ? r_cnt : r_cnt + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_prod  <= '0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
         r_sel   <= '0;
         r_wstrb <= 1'b0;
         r_rstrb <= 1'b0;
         r_wdata <= '0;
      end else begin
         // Bus outputs describe the state being entered; idle bus unless set below
         r_sel   <= 2'd0;
         r_wstrb <= 1'b0;
         r_rstrb <= 1'b0;
         r_wdata <= 32'd0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_cnt   <= '0;
                  r_state <= S_WAIT_FREE;
               end
            end
            S_WAIT_FREE: begin
               if (!wbusy) begin
                  r_state <= S_WR_A;
                  r_wstrb <= 1'b1;
                  r_sel   <= 2'd0;
                  r_wdata <= r_a;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == c_timeout) begin
                     r_state <= S_OUT;
                     r_valid <= 1'b1;
                     r_err   <= 1'b1;
                     r_prod  <= '0;
                  end
               end
            end
            S_WR_A: begin
               r_state <= S_WR_B;
               r_wstrb <= 1'b1;
               r_sel   <= 2'd1;
               r_wdata <= r_b;
            end
            S_WR_B: begin
               r_state <= S_WR_START;
               r_wstrb <= 1'b1;
               r_sel   <= 2'd2;
               r_wdata <= 32'd1;
            end
            S_WR_START: begin
               r_cnt   <= '0;
               r_state <= S_POLL;
               r_rstrb <= 1'b1;
               r_sel   <= 2'd2;
            end
            S_POLL: begin
               if (!rdata[0]) begin
                  r_state <= S_RD_RES;
                  r_rstrb <= 1'b1;
                  r_sel   <= 2'd3;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == c_timeout) begin
                     r_state <= S_OUT;
                     r_valid <= 1'b1;
                     r_err   <= 1'b1;
                     r_prod  <= '0;
                  end else begin
                     r_rstrb <= 1'b1;
                     r_sel   <= 2'd2;
                  end
               end
            end
            S_RD_RES: begin
               r_prod  <= rdata;
               r_err   <= 1'b0;
               r_valid <= 1'b1;
               r_state <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = (r_state == S_IDLE);
   assign out_valid   = r_valid;
   assign out_product = r_prod;
   assign out_err     = r_err;
   assign sel         = r_sel;
   assign wstrb       = r_wstrb;
   assign rstrb       = r_rstrb;
   assign wdata       = r_wdata;

endmodule
`default_nettype wire
